shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Command-driven controller that sequences an N-bit bidirectional shift register.
- Accepts a word, direction and shift count over a valid/ready command channel.
- Steps the internal register one position per clock, exposing each shifted-out bit serially.
- Presents the final word on a valid/ready result channel.
- Sits between a bus-side requester and the shift datapath, so the datapath is never driven ad hoc from the testbench or top level.

Parameters:
N, 8, data width in bits (N >= 2)
CNT_W, $clog2(N+1), width of the shift-count field

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command
cmd_data  input  N  word to load
cmd_dir  input  1  1 = shift right, 0 = shift left
cmd_count  input  CNT_W  number of single-bit shifts
res_valid  output  1  result word available
res_ready  input  1  consumer accepts result
res_data  output  N  shifted word
ser_out  output  1  bit shifted out on the current step
ser_valid  output  1  ser_out is meaningful this cycle
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; shift register = 0; remaining count = 0; latched direction = 0.
  - cmd_ready = 1, res_valid = 0, res_data = 0, ser_out = 0, ser_valid = 0, busy = 0.
  - Reset deasserting is synchronised externally; the block needs no extra release logic.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1.
  - On a clock edge with cmd_valid = 1: load cmd_data, latch cmd_dir, latch the effective count = min(cmd_count, N).
  - If the effective count = 0, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - One shift per clock. Right: reg <= reg >> 1, shifted-out bit = reg[0]. Left: reg <= reg << 1, shifted-out bit = reg[N-1]. Vacated bits are filled with 0.
  - ser_out = bit leaving on this edge, combinational from the current reg and direction; ser_valid = 1.
  - Remaining count decrements each cycle. The shift performed when remaining = 1 is the last; the next state is DONE.
  - cmd_ready = 0; cmd_valid is ignored.
- DONE:
  - res_valid = 1 and res_data = reg, both held stable until res_ready = 1.
  - On the edge with res_ready = 1: go to IDLE.
  - cmd_ready = 0 in DONE (no bypass); a new command is accepted no earlier than the cycle after the handshake.
- Latency:
  - Command accepted at edge E0 → res_valid high after edge E0+k, where k = effective count.
  - k = 0 → res_valid high the cycle after acceptance.
  - Throughput: one command per k+2 cycles with res_ready tied high.
- Boundary conditions:
  - cmd_count > N saturates to N; the logical result is then all zeros.
  - A direction change on cmd_dir during SHIFT has no effect; direction is latched at acceptance.
  - res_ready asserted outside DONE is ignored.
  - Reset asserted mid-SHIFT or in DONE discards the command; no partial result is presented.
- res_data is a registered output. In states other than DONE it shows the live shift register contents, which consumers ignore.

Optional Feature:
- Macro: SHIFT_SEQUENCER_ROTATE_EN.
- Defined:
  - Adds input cmd_rotate (1 bit), latched at acceptance.
  - When latched high, the vacated bit is filled with the outgoing bit: right rotates reg[0] into bit N-1, left rotates reg[N-1] into bit 0. ser_out is unchanged.
  - Counts are taken modulo N instead of saturating; count N behaves as 0.
- Undefined:
  - The cmd_rotate port is absent. Logical shift with zero fill and saturation only.

Decomposition:
- Package shift_sequencer_pkg:
  - state enum: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - Direction constants: DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
- One sub-module, shift_sequencer_dp: the N-bit register with load, shift-enable, direction and fill-bit inputs, plus the outgoing-bit output.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then load 8'b10101010, dir = right, count = 3, res_ready = 1:
  - ser_out sequence 0, 1, 0; res_data = 8'b00010101; res_valid high exactly 3 cycles after acceptance.
- Load 8'hF0, dir = left, count = 0:
  - res_valid the next cycle with res_data = 8'hF0; ser_valid never asserts.
- Load 8'hFF, dir = left, count = 15 (saturates to 8):
  - 8 shift cycles, all ser_out = 1, res_data = 8'h00.
- Result backpressure: hold res_ready = 0 for 5 cycles in DONE:
  - res_valid and res_data stable throughout; cmd_ready = 0; a command offered meanwhile is accepted only after the handshake.
- Assert reset = 0 mid-SHIFT (after 2 of 5 shifts):
  - All outputs return to reset values immediately; after release, a new command runs correctly from IDLE.
- With SHIFT_SEQUENCER_ROTATE_EN defined: load 8'b10000001, rotate = 1, dir = right, count = 9:
  - Count wraps to 1; res_data = 8'b11000000.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg
// Shared types and constants for the shift sequencer slice.
//   state_t   : controller state encoding (IDLE, SHIFT, DONE)
//   DIR_LEFT  : cmd_dir value selecting a left shift
//   DIR_RIGHT : cmd_dir value selecting a right shift
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_dp.sv
// shift_sequencer_dp
// N-bit bidirectional shift register used as the sequencer's datapath.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset, clears the register
//   load      : load load_data this edge (takes priority over shift_en)
//   load_data : word to load
//   shift_en  : shift one position this edge
//   dir       : 1 = shift right, 0 = shift left
//   fill      : bit entering the vacated position
//   q         : current register contents
//   out_bit   : bit that leaves on the next shift in direction dir
module shift_sequencer_dp
  import shift_sequencer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  input  logic         dir,
  input  logic         fill,
  output logic [N-1:0] q,
  output logic         out_bit
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) begin
        q <= {fill, q[N-1:1]};
      end else begin
        q <= {q[N-2:0], fill};
      end
    end
  end

  assign out_bit = (dir == DIR_RIGHT) ? q[0] : q[N-1];

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Command-driven controller that loads a word into the shift datapath,
// steps it one position per clock while exposing each outgoing bit, and
// presents the final word on a valid/ready result channel.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN adds cmd_rotate; when
// latched high the outgoing bit is fed back into the vacated position and
// counts wrap modulo N instead of saturating.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_data/dir/count     : word, direction (1 = right), shift count
//   cmd_rotate             : rotate instead of zero fill (macro only)
//   res_valid/res_ready    : result handshake
//   res_data               : shifted word
//   ser_out/ser_valid      : bit leaving on the current step
//   busy                   : high outside IDLE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] eff_count;
  logic             dir_q;
  logic             fill;
  logic             out_bit;
  logic             accept;

  assign accept = (state == IDLE) && cmd_valid;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic rotate_q;

  // A CNT_W-bit count never reaches 2N, so one conditional subtract
  // is enough to reduce it modulo N.
  always_comb begin
    eff_count = cmd_count;
    if (cmd_count >= N_CNT) begin
      eff_count = cmd_count - N_CNT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rotate_q <= 1'b0;
    end else if (accept) begin
      rotate_q <= cmd_rotate;
    end
  end

  assign fill = rotate_q & out_bit;
`else
  // Shifting more than N places yields the same all-zero word as N.
  always_comb begin
    eff_count = cmd_count;
    if (cmd_count > N_CNT) begin
      eff_count = N_CNT;
    end
  end

  assign fill = 1'b0;
`endif

  shift_sequencer_dp #(.N(N)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data (cmd_data),
    .shift_en  (state == SHIFT),
    .dir       (dir_q),
    .fill      (fill),
    .q         (res_data),
    .out_bit   (out_bit)
  );

  // Handshake and status flags are registered alongside the state so
  // they always change together on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= DIR_LEFT;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            remaining <= eff_count;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (eff_count == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state     <= SHIFT;
              ser_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state     <= DONE;
            ser_valid <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Gated so the serial line reads 0 whenever no step is in progress.
  assign ser_out = ser_valid & out_bit;

endmodule
